// File: rtl/rng_pkg.sv
// Shared constants and the state type for the chip8 RNG LFSR.
// Used by lfsr_step and rng_lfsr.
package rng_pkg;

  typedef logic [15:0] lfsr_state_t;

  // x^16+x^14+x^13+x^11+1 in right-shift Galois form (maximal length)
  localparam lfsr_state_t POLY         = 16'hB400;
  localparam lfsr_state_t DEFAULT_SEED = 16'hACE1;
  localparam lfsr_state_t GUARD_STATE  = 16'h0001;

endpackage : rng_pkg

// File: rtl/rng_lfsr_step.sv
// One combinational Galois right-shift step of the 16-bit RNG LFSR.
module lfsr_step
  import rng_pkg::*;
(
  input  lfsr_state_t s_i,
  output lfsr_state_t s_o
);

  always_comb begin
    s_o = s_i >> 1;
    if (s_i[0]) begin
      s_o = s_o ^ POLY;
    end
  end

endmodule : lfsr_step

// File: rtl/rng_lfsr.sv
// Free-running pseudo-random byte source: STEPS_PER_CLK chained LFSR steps per clock.
// Optional zero-state lockup guard enabled by defining RNG_LOCKUP_GUARD_EN.
module rng_lfsr
  import rng_pkg::*;
#(
  parameter lfsr_state_t SEED          = DEFAULT_SEED,
  parameter int          STEPS_PER_CLK = 8   // legal range 1..16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] x
);

  lfsr_state_t state_q;
  lfsr_state_t state_d;
  lfsr_state_t next_raw;

  // chain[0] is the current state, chain[STEPS_PER_CLK] the fully advanced one
  lfsr_state_t chain [0:STEPS_PER_CLK];

  assign chain[0] = state_q;

  for (genvar g = 0; g < STEPS_PER_CLK; g++) begin : g_step
    lfsr_step u_step (
      .s_i (chain[g]),
      .s_o (chain[g+1])
    );
  end

  always_comb begin
    next_raw = chain[STEPS_PER_CLK];
    if (rst) begin
      next_raw = SEED;
    end
    state_d = next_raw;
`ifdef RNG_LOCKUP_GUARD_EN
    // zero is a fixed point of the step; never let it into the register
    if (next_raw == 16'h0000) begin
      state_d = GUARD_STATE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign x = state_q[7:0];

endmodule : rng_lfsr

// File: tb/tb_rng_lfsr.sv
// Scoreboard bench for rng_lfsr: default, single-step and zero-seed instances share clk/rst.
module tb_rng_lfsr;

  logic       clk;
  logic       rst;
  logic [7:0] x_def;
  logic [7:0] x_one;
  logic [7:0] x_zero;

  int checks = 0;
  int errors = 0;

  // entry: {check mask [def,one,zero], exp_def, exp_one, exp_zero}
  logic [26:0] exp_q[$];

  rng_lfsr u_dut_def (
    .clk (clk),
    .rst (rst),
    .x   (x_def)
  );

  rng_lfsr #(.STEPS_PER_CLK(1)) u_dut_one (
    .clk (clk),
    .rst (rst),
    .x   (x_one)
  );

  rng_lfsr #(.SEED(16'h0000)) u_dut_zero (
    .clk (clk),
    .rst (rst),
    .x   (x_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: apply rst for one edge and queue what each instance must show after it
  task automatic drive(input logic r, input logic [2:0] m,
                       input logic [7:0] e_def, input logic [7:0] e_one, input logic [7:0] e_zero);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    exp_q.push_back({m, e_def, e_one, e_zero});
  endtask

  // monitor: x is stable at the falling edge following the edge that produced it
  always @(negedge clk) begin
    logic [26:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[26]) check("x_def",  {24'h0, x_def},  {24'h0, e[23:16]});
      if (e[25]) check("x_one",  {24'h0, x_one},  {24'h0, e[15:8]});
      if (e[24]) check("x_zero", {24'h0, x_zero}, {24'h0, e[7:0]});
    end
  end

  logic [7:0] one_seq [0:7];
  logic [7:0] zero_rst;
  logic [7:0] zero_next;
  logic       zero_check_all;

  initial begin
    int  cnt;
    bit  seen_zero;
    bit  found;
    one_seq[0] = 8'h70; one_seq[1] = 8'h38; one_seq[2] = 8'h9C; one_seq[3] = 8'h4E;
    one_seq[4] = 8'h27; one_seq[5] = 8'h13; one_seq[6] = 8'h89; one_seq[7] = 8'hC4;
`ifdef RNG_LOCKUP_GUARD_EN
    zero_rst = 8'h01; zero_next = 8'h68; zero_check_all = 1'b0;
`else
    zero_rst = 8'h00; zero_next = 8'h00; zero_check_all = 1'b1;
`endif

    // reset edge
    drive(1'b1, 3'b111, 8'hE1, 8'hE1, zero_rst);
    // 16 free-running clocks
    for (int i = 0; i < 16; i++) begin
      logic [2:0] m;
      logic [7:0] ed;
      ed = (i == 0) ? 8'hC4 : 8'h62;
      m[2] = (i < 2);
      m[1] = (i < 8);
      m[0] = zero_check_all || (i == 0);
      drive(1'b0, m, ed, (i < 8) ? one_seq[i] : 8'h00, (i == 0) ? zero_next : 8'h00);
    end
    // mid-run reset restarts exactly from SEED
    drive(1'b1, 3'b111, 8'hE1, 8'hE1, zero_rst);
    drive(1'b0, 3'b111, 8'hC4, 8'h70, zero_next);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    // full period of the default instance
    drive(1'b1, 3'b000, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    seen_zero = 1'b0;
    found = 1'b0;
    while (!found && cnt < 70000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (u_dut_def.state_q == 16'h0000) seen_zero = 1'b1;
      if (u_dut_def.state_q == 16'hACE1) found = 1'b1;
    end
    check("period_found", {31'h0, found}, 32'd1);
    check("period_len", cnt, 32'd65535);
    check("never_zero", {31'h0, seen_zero}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rng_lfsr
